// File: rtl/store_buffer_packer_pkg.sv
// Shared encodings for the store buffer: operand size codes and the full-word byte-enable mask.
package store_buffer_packer_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_ILL  = 2'b11
  } st_size_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational lane packer: narrows a store operand to its byte lanes and flags misaligned/illegal sizes.
module store_lane_pack
  import store_buffer_packer_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  // Lane selection and data replication per operand size
  always_comb begin
    be       = 4'b0000;
    wdata    = 32'h0000_0000;
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SIZE_HALF: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{data[15:0]}};
        misalign = addr_lo[0];
      end
      SIZE_WORD: begin
        be       = BE_ALL;
        wdata    = data;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        be       = 4'b0000;
        wdata    = 32'h0000_0000;
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer_packer.sv
// Store buffer: packs MEM-stage stores into word-aligned lane writes and queues them toward data memory.
module store_buffer_packer
  import store_buffer_packer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     st_err,
  output logic                     dm_valid,
  input  logic                     dm_ready,
  output logic [AW-1:0]            dm_addr,
  output logic [31:0]              dm_wdata,
  output logic [3:0]               dm_be,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-3:0]   mem_addr_r  [DEPTH];
  logic [31:0]     mem_wdata_r [DEPTH];
  logic [3:0]      mem_be_r    [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            st_err_r;

  logic [3:0]      pack_be_s;
  logic [31:0]     pack_wdata_s;
  logic            pack_misalign_s;
  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            dm_valid_s;

  store_lane_pack u_pack (
    .addr_lo  (st_addr[1:0]),
    .size     (st_size),
    .data     (st_data),
    .be       (pack_be_s),
    .wdata    (pack_wdata_s),
    .misalign (pack_misalign_s)
  );

  // Handshake decode; dm_valid is suppressed during reset so no write escapes in the reset cycle
  always_comb begin
    st_ready   = (count_r != FULL_CNT);
    dm_valid_s = (count_r != {CW{1'b0}}) && !reset;
    accept_s   = st_valid && st_ready;
    push_s     = accept_s && !pack_misalign_s;
    pop_s      = dm_valid_s && dm_ready;
  end

  // FIFO payload storage, written only for legal accepted stores
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_addr_r[wr_ptr_r]  <= st_addr[AW-1:2];
      mem_wdata_r[wr_ptr_r] <= pack_wdata_s;
      mem_be_r[wr_ptr_r]    <= pack_be_s;
    end
  end

  // Pointers, occupancy and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      st_err_r <= 1'b0;
    end else begin
      st_err_r <= accept_s && pack_misalign_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry presentation; all zeros while empty
  always_comb begin
    if (dm_valid_s) begin
      dm_addr  = {mem_addr_r[rd_ptr_r], 2'b00};
      dm_wdata = mem_wdata_r[rd_ptr_r];
      dm_be    = mem_be_r[rd_ptr_r];
    end else begin
      dm_addr  = {AW{1'b0}};
      dm_wdata = 32'h0000_0000;
      dm_be    = 4'b0000;
    end
  end

  assign dm_valid = dm_valid_s;
  assign count    = count_r;
  assign st_err   = st_err_r;

endmodule

// File: tb/tb_store_buffer_packer.sv
// Directed self-checking bench for store_buffer_packer (DEPTH=2, AW=32).
module tb_store_buffer_packer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_err;
  logic        dm_valid;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [1:0]  count;

  int n_checks;
  int n_errors;
  int pops;

  store_buffer_packer #(.DEPTH(2), .AW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_size  (st_size),
    .st_err   (st_err),
    .dm_valid (dm_valid),
    .dm_ready (dm_ready),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    dm_ready = 1'b0;
    drive_st(1'b0, 32'h0, 32'h0, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_count", {30'd0, count}, 32'd0);
    check("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
    check("rst_st_err", {31'd0, st_err}, 32'd0);
    check("rst_st_ready", {31'd0, st_ready}, 32'd1);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_be", {28'd0, dm_be}, 32'd0);

    // sb to byte lane 3
    drive_st(1'b1, 32'h13, 32'h0000_00AB, 2'b10);
    @(negedge clk);
    drive_st(1'b0, 32'h0, 32'h0, 2'b00);
    check("sb_valid", {31'd0, dm_valid}, 32'd1);
    check("sb_addr", dm_addr, 32'h10);
    check("sb_wdata", dm_wdata, 32'hABAB_ABAB);
    check("sb_be", {28'd0, dm_be}, 32'h8);
    check("sb_count", {30'd0, count}, 32'd1);
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
    check("sb_drained", {30'd0, count}, 32'd0);
    check("sb_empty_addr", dm_addr, 32'd0);

    // sh upper half, then misaligned sh
    drive_st(1'b1, 32'h22, 32'h1234_BEEF, 2'b01);
    @(negedge clk);
    drive_st(1'b0, 32'h0, 32'h0, 2'b00);
    check("sh_addr", dm_addr, 32'h20);
    check("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
    check("sh_be", {28'd0, dm_be}, 32'hC);
    check("sh_err_clear", {31'd0, st_err}, 32'd0);
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
    drive_st(1'b1, 32'h21, 32'h1234_BEEF, 2'b01);
    @(negedge clk);
    drive_st(1'b1, 32'h40, 32'h5555_5555, 2'b11);
    check("mis_sh_err", {31'd0, st_err}, 32'd1);
    check("mis_sh_count", {30'd0, count}, 32'd0);
    @(negedge clk);
    drive_st(1'b1, 32'h46, 32'h6666_6666, 2'b00);
    check("ill_err", {31'd0, st_err}, 32'd1);
    @(negedge clk);
    drive_st(1'b0, 32'h0, 32'h0, 2'b00);
    check("mis_w_err", {31'd0, st_err}, 32'd1);
    check("mis_w_count", {30'd0, count}, 32'd0);
    @(negedge clk);
    check("err_pulse_end", {31'd0, st_err}, 32'd0);
    check("err_no_valid", {31'd0, dm_valid}, 32'd0);

    // Fill the buffer with dm_ready low
    drive_st(1'b1, 32'h100, 32'h1111_1111, 2'b00);
    @(negedge clk);
    check("fill1_count", {30'd0, count}, 32'd1);
    drive_st(1'b1, 32'h104, 32'h2222_2222, 2'b00);
    @(negedge clk);
    check("full_count", {30'd0, count}, 32'd2);
    check("full_ready", {31'd0, st_ready}, 32'd0);
    drive_st(1'b1, 32'h108, 32'h3333_3333, 2'b00);
    repeat (2) @(negedge clk);
    check("full_hold_count", {30'd0, count}, 32'd2);
    check("full_hold_addr", dm_addr, 32'h100);
    check("full_hold_wdata", dm_wdata, 32'h1111_1111);
    check("full_hold_be", {28'd0, dm_be}, 32'hF);

    // Full buffer pops once while input still offered: no push
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
    drive_st(1'b0, 32'h0, 32'h0, 2'b00);
    check("pop_full_count", {30'd0, count}, 32'd1);
    check("pop_full_ready", {31'd0, st_ready}, 32'd1);
    check("pop_full_addr", dm_addr, 32'h104);
    check("pop_full_wdata", dm_wdata, 32'h2222_2222);
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
    check("drain_count", {30'd0, count}, 32'd0);

    // Streaming ten word stores
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      drive_st(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 2'b00);
      dm_ready = 1'b1;
      if (dm_valid) begin
        check("stream_addr", dm_addr, 32'(pops * 4));
        check("stream_wdata", dm_wdata, 32'hA0 + 32'(pops));
        pops++;
      end
      @(negedge clk);
      check("stream_count", {30'd0, count}, 32'd1);
    end
    drive_st(1'b0, 32'h0, 32'h0, 2'b00);
    if (dm_valid) begin
      check("stream_addr", dm_addr, 32'(pops * 4));
      check("stream_wdata", dm_wdata, 32'hA0 + 32'(pops));
      pops++;
    end
    @(negedge clk);
    dm_ready = 1'b0;
    check("stream_end_count", {30'd0, count}, 32'd0);
    check("stream_pops", 32'(pops), 32'd10);

    // Reset with two entries queued and an illegal store offered
    drive_st(1'b1, 32'h200, 32'h7777_7777, 2'b00);
    @(negedge clk);
    drive_st(1'b1, 32'h204, 32'h8888_8888, 2'b00);
    @(negedge clk);
    check("pre_rst_count", {30'd0, count}, 32'd2);
    drive_st(1'b1, 32'h0, 32'h0, 2'b11);
    reset    = 1'b1;
    dm_ready = 1'b1;
    #1;
    check("rst_cycle_valid", {31'd0, dm_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_st(1'b0, 32'h0, 32'h0, 2'b00);
    check("mid_rst_count", {30'd0, count}, 32'd0);
    check("mid_rst_valid", {31'd0, dm_valid}, 32'd0);
    check("mid_rst_err", {31'd0, st_err}, 32'd0);
    check("mid_rst_addr", dm_addr, 32'd0);
    repeat (2) @(negedge clk);
    check("post_rst_valid", {31'd0, dm_valid}, 32'd0);
    check("post_rst_count", {30'd0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
